// File: rtl/exe_stage_mc.sv
// -----------------------------------------------------------------------------
// exe_stage_mc
//
// Execute stage of the pipeline. It takes the decoded bundle from the ID/EXE
// register and produces the EXE/MEM bundle.
//
// Single-cycle operations resolve combinationally:
//   - arithmetic
//   - logic
//   - shift
//   - move-from-HILO
//   - load/store address generation
//
// MULT is handled differently. It is computed by an iterative signed
// multiplier that retires MUL_BITS_PER_CYCLE multiplier bits per cycle.
// While it runs, stallreq_exe holds the front of the pipe. When the 64-bit
// product is ready it is presented on the HILO write path for one cycle.
//
// Optional feature (compile-time macro EXE_HILO_FWD_EN):
//   When defined, it adds the MEM and WB HILO forwarding inputs. MFHI/MFLO
//   then select their source in this order: MEM, then WB, then hi_i/lo_i.
//
// Parameter:
//   MUL_BITS_PER_CYCLE  multiplier bits per iteration (1, 2 or 4)
//
// Ports:
//   cpu_clk_50M, cpu_rst_n       clock, asynchronous active-low reset
//   exe_alutype_i, exe_aluop_i   operation class and operation code
//   exe_src1_i, exe_src2_i       operands (src1[4:0] is the SLL shift amount)
//   exe_din_i                    store data
//   exe_wa_i, exe_wreg_i         destination register and GPR write enable
//   exe_whilo_i                  HILO write enable, qualifies the MULT start
//   exe_mreg_i                   load-result select
//   hi_i, lo_i                   architectural HI/LO
//   mem_whilo_i, mem_hilo_i      MEM-stage HILO write (EXE_HILO_FWD_EN only)
//   wb_whilo_i, wb_hilo_i        WB-stage HILO write (EXE_HILO_FWD_EN only)
//   exe_aluop_o .. exe_din_o     pass-through fields to EXE/MEM
//   exe_wd_o                     result or memory address
//   exe_whilo_o, exe_hilo_o      HILO write strobe and {hi,lo} product
//   stallreq_exe                 stall request to PC, IF/ID and ID/EXE
// -----------------------------------------------------------------------------
module exe_stage_mc #(
   parameter int MUL_BITS_PER_CYCLE = 2
) (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst_n,
   input  logic [2:0]  exe_alutype_i,
   input  logic [7:0]  exe_aluop_i,
   input  logic [31:0] exe_src1_i,
   input  logic [31:0] exe_src2_i,
   input  logic [31:0] exe_din_i,
   input  logic [4:0]  exe_wa_i,
   input  logic        exe_wreg_i,
   input  logic        exe_whilo_i,
   input  logic        exe_mreg_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
`ifdef EXE_HILO_FWD_EN
   input  logic        mem_whilo_i,
   input  logic [63:0] mem_hilo_i,
   input  logic        wb_whilo_i,
   input  logic [63:0] wb_hilo_i,
`endif
   output logic [7:0]  exe_aluop_o,
   output logic [4:0]  exe_wa_o,
   output logic        exe_wreg_o,
   output logic        exe_mreg_o,
   output logic [31:0] exe_din_o,
   output logic [31:0] exe_wd_o,
   output logic        exe_whilo_o,
   output logic [63:0] exe_hilo_o,
   output logic        stallreq_exe
);

   localparam int         ITER     = 32 / MUL_BITS_PER_CYCLE;
   localparam logic [4:0] CNT_INIT = 5'(ITER - 1);

   localparam logic [7:0] OP_ADD   = 8'h18;
   localparam logic [7:0] OP_ADDIU = 8'h19;
   localparam logic [7:0] OP_SUBU  = 8'h1B;
   localparam logic [7:0] OP_AND   = 8'h1C;
   localparam logic [7:0] OP_ORI   = 8'h1D;
   localparam logic [7:0] OP_LUI   = 8'h05;
   localparam logic [7:0] OP_SLT   = 8'h26;
   localparam logic [7:0] OP_SLTIU = 8'h27;
   localparam logic [7:0] OP_SLL   = 8'h11;
   localparam logic [7:0] OP_MFHI  = 8'h0C;
   localparam logic [7:0] OP_MFLO  = 8'h0D;
   localparam logic [7:0] OP_LB    = 8'h90;
   localparam logic [7:0] OP_LW    = 8'h92;
   localparam logic [7:0] OP_SB    = 8'h98;
   localparam logic [7:0] OP_SW    = 8'h9A;
   localparam logic [7:0] OP_MULT  = 8'h14;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [4:0]  count;
   logic [63:0] acc;
   logic [63:0] mcand;
   logic [31:0] mplier;
   logic        neg_result;
   logic        start_mul;
   logic        stall_raw;
   logic        whilo_raw;
   logic [63:0] hilo_raw;
   logic [63:0] partial;
   logic [63:0] product;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic [31:0] hi_src;
   logic [31:0] lo_src;
   logic [31:0] alu_result;
   logic        unused_ok;

   // The op class is redundant here: aluop alone identifies every operation.
   assign unused_ok = ^exe_alutype_i;

   // Operand magnitudes. Taken as unsigned 32-bit values, |0x80000000| is
   // still exact (2^31), so the edge operands need no extra bit.
   assign mag1 = exe_src1_i[31] ? (~exe_src1_i + 32'd1) : exe_src1_i;
   assign mag2 = exe_src2_i[31] ? (~exe_src2_i + 32'd1) : exe_src2_i;

   assign product = neg_result ? (~acc + 64'd1) : acc;

`ifdef EXE_HILO_FWD_EN
   // The youngest HILO writer wins: MEM first, then WB, then the
   // architectural registers.
   always_comb begin
      hi_src = hi_i;
      lo_src = lo_i;
      if (mem_whilo_i) begin
         hi_src = mem_hilo_i[63:32];
         lo_src = mem_hilo_i[31:0];
      end else if (wb_whilo_i) begin
         hi_src = wb_hilo_i[63:32];
         lo_src = wb_hilo_i[31:0];
      end
   end
`else
   // Without forwarding, software keeps MFHI/MFLO two instructions
   // behind MULT, so the architectural HI/LO are always current.
   assign hi_src = hi_i;
   assign lo_src = lo_i;
`endif

   // Single-cycle result mux. Load and store operations reuse the adder
   // to form the memory address.
   always_comb begin
      alu_result = 32'd0;
      case (exe_aluop_i)
         OP_ADD, OP_ADDIU, OP_LB, OP_LW, OP_SB, OP_SW:
            alu_result = exe_src1_i + exe_src2_i;
         OP_SUBU:  alu_result = exe_src1_i - exe_src2_i;
         OP_AND:   alu_result = exe_src1_i & exe_src2_i;
         OP_ORI:   alu_result = exe_src1_i | exe_src2_i;
         OP_LUI:   alu_result = exe_src2_i;
         OP_SLT:   alu_result = {31'd0, $signed(exe_src1_i) < $signed(exe_src2_i)};
         OP_SLTIU: alu_result = {31'd0, exe_src1_i < exe_src2_i};
         OP_SLL:   alu_result = exe_src2_i << exe_src1_i[4:0];
         OP_MFHI:  alu_result = hi_src;
         OP_MFLO:  alu_result = lo_src;
         default:  alu_result = 32'd0;
      endcase
   end

   // Partial product for this iteration. Each low multiplier bit adds a
   // suitably shifted copy of the multiplicand.
   always_comb begin
      partial = 64'd0;
      for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
         if (mplier[i]) begin
            partial = partial + (mcand << i);
         end
      end
   end

   // Multiplier FSM state register.
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and output logic. The stall rises in the accepting IDLE
   // cycle itself, so the ID/EXE register already holds the MULT on the
   // next edge. DONE always returns to IDLE. That lets a back-to-back MULT
   // be accepted in the very next cycle.
   always_comb begin
      next_state = state;
      start_mul  = 1'b0;
      stall_raw  = 1'b0;
      whilo_raw  = 1'b0;
      hilo_raw   = 64'd0;
      case (state)
         IDLE: begin
            if (exe_aluop_i == OP_MULT && exe_whilo_i) begin
               start_mul  = 1'b1;
               stall_raw  = 1'b1;
               next_state = BUSY;
            end
         end
         BUSY: begin
            stall_raw = 1'b1;
            if (count == 5'd0) begin
               next_state = DONE;
            end
         end
         DONE: begin
            whilo_raw  = 1'b1;
            hilo_raw   = product;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Multiplier datapath. It works unsigned on the operand magnitudes and
   // fixes the sign only when the product is presented.
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         count      <= 5'd0;
         acc        <= 64'd0;
         mcand      <= 64'd0;
         mplier     <= 32'd0;
         neg_result <= 1'b0;
      end else if (start_mul) begin
         count      <= CNT_INIT;
         acc        <= 64'd0;
         mcand      <= {32'd0, mag1};
         mplier     <= mag2;
         neg_result <= exe_src1_i[31] ^ exe_src2_i[31];
      end else if (state == BUSY) begin
         acc    <= acc + partial;
         mcand  <= mcand << MUL_BITS_PER_CYCLE;
         mplier <= mplier >> MUL_BITS_PER_CYCLE;
         if (count != 5'd0) begin
            count <= count - 5'd1;
         end
      end
   end

   // Every output is forced to zero while reset is held low, including
   // the combinational pass-through paths.
   always_comb begin
      exe_aluop_o  = 8'd0;
      exe_wa_o     = 5'd0;
      exe_wreg_o   = 1'b0;
      exe_mreg_o   = 1'b0;
      exe_din_o    = 32'd0;
      exe_wd_o     = 32'd0;
      exe_whilo_o  = 1'b0;
      exe_hilo_o   = 64'd0;
      stallreq_exe = 1'b0;
      if (cpu_rst_n) begin
         exe_aluop_o  = exe_aluop_i;
         exe_wa_o     = exe_wa_i;
         exe_wreg_o   = exe_wreg_i;
         exe_mreg_o   = exe_mreg_i;
         exe_din_o    = exe_din_i;
         exe_wd_o     = alu_result;
         exe_whilo_o  = whilo_raw;
         exe_hilo_o   = hilo_raw;
         stallreq_exe = stall_raw;
      end
   end

endmodule
